rr_arb_mux: RTL and testbench
=============================

// Module: rr_arb_mux
// PURPOSE
//   Parametrised N-channel, WIDTH-bit arbitrating multiplexer; successor to the fixed 8:1 1-bit mux.
//   Selection is no longer an external select bus. An internal arbiter picks one requesting channel,
//   in round-robin or fixed-priority mode.
//   The chosen word is registered and presented on a valid/ready output port.
//   Sits between multiple result producers (ALU slices, shifter, mult) and a single writeback consumer.
// PARAMETERS
//   WIDTH   32              data bits per channel (>=1)
//   N       8               number of input channels (>=2)
//   SEL_W   $clog2(N)       width of channel index (derived; do not override)
// PORTS
//   clk        in   1          single clock, rising edge
//   reset      in   1          synchronous, active-high reset
//   prio_mode  in   1          0 = round-robin, 1 = fixed priority (channel 0 highest)
//   in_valid   in   N          per-channel request
//   in_data    in   N*WIDTH    channel i occupies bits [i*WIDTH +: WIDTH]
//   in_ready   out  N          one-hot (or zero) accept strobe, combinational
//   out_valid  out  1          output register holds a word
//   out_data   out  WIDTH      registered selected word
//   out_sel    out  SEL_W      index of the channel that supplied out_data
//   out_ready  in   1          consumer accepts out_data this cycle
// BEHAVIOUR
//   - Reset (sampled at posedge while reset=1):
//       out_valid=0, out_data=0, out_sel=0, rr_ptr=N-1 (so channel 0 wins first RR arbitration).
//       in_ready is 0 while reset=1.
//   - load = !out_valid | out_ready. Arbitration happens only when load=1; a drain and a refill
//     may occur in the same cycle.
//   - Grant (combinational, from in_valid):
//       RR: first i with in_valid[i]=1, scanning rr_ptr+1, rr_ptr+2, ... mod N (wrap-around).
//       FP: lowest i with in_valid[i]=1.
//   - in_ready[i] = load & grant[i]. At most one bit is set; all bits are 0 when no request is
//     present or load=0.
//   - Transfer: in_valid[i] & in_ready[i] at posedge ->
//       out_data <= in_data[i], out_sel <= i, out_valid <= 1, rr_ptr <= i.
//       rr_ptr is updated in both modes.
//   - Latency: 1 cycle input->output. Throughput: 1 word/cycle when out_ready is held 1.
//   - If load=1 and no request is present: out_valid <= 0 (when out_ready drained it);
//     out_data and out_sel hold their last values.
//   - Stall: out_valid=1 & out_ready=0 -> out_data, out_sel and out_valid stay stable;
//     all in_ready=0; rr_ptr holds.
//   - prio_mode is sampled combinationally and takes effect on the next arbitration.
//     A word already registered is unaffected.
//   - Fairness: in RR mode with all N requests held, grants cycle 0,1,..,N-1,0,... with no channel
//     starving longer than N-1 transfers.
//   - Reset asserted mid-stall discards the held word; no in_ready is issued in that cycle.
//   - in_valid must not depend combinationally on in_ready (no loop). Producers hold
//     data and valid until accepted.
// TESTING
//   1 reset: assert reset 2 cycles with in_valid=8'hFF -> out_valid=0, out_data=0, in_ready=0;
//     after release, first grant is ch0.
//   2 RR cycling: N=8, WIDTH=32, in_data[i]=32'hA0+i, in_valid=8'hFF, out_ready=1 ->
//     out_sel 0..7,0 on consecutive cycles, out_data=32'hA0..32'hA7.
//   3 RR wrap/skip: rr_ptr=6, in_valid=8'b0000_0101 -> grant ch0, then ch2, then ch0.
//   4 fixed priority: prio_mode=1, in_valid=8'b1001_0100 held -> ch2 granted every cycle;
//     drop ch2 -> ch4 granted.
//   5 backpressure: out_valid=1 with out_sel=3, data=32'hDEAD_BEEF, out_ready=0 for 5 cycles ->
//     outputs stable, in_ready=0; out_ready=1 -> next word loaded the same edge.
//   6 reset mid-stall: reset during test 5 stall -> out_valid=0 next cycle, no in_ready pulse,
//     rr_ptr=7.

Source files
------------

// File: rtl/rr_arb_mux.sv
// N-channel arbitrating multiplexer: a round-robin or fixed-priority arbiter picks one
// requesting channel and registers its word onto a single valid/ready output port.
module rr_arb_mux #(
    parameter int WIDTH = 32,
    parameter int N     = 8,
    localparam int SEL_W = $clog2(N)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               prio_mode,
    input  logic [N-1:0]       in_valid,
    input  logic [N*WIDTH-1:0] in_data,
    output logic [N-1:0]       in_ready,
    output logic               out_valid,
    output logic [WIDTH-1:0]   out_data,
    output logic [SEL_W-1:0]   out_sel,
    input  logic               out_ready
);

    // Valid/ready: a word moves on any rising edge where valid and ready are both high.
    // Producers hold valid and data until accepted, and in_valid never depends on in_ready.
    // The output register may be drained and refilled on the same edge.

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q,  out_data_d;
    logic [SEL_W-1:0] out_sel_q,   out_sel_d;
    logic [SEL_W-1:0] rr_ptr_q,    rr_ptr_d;

    logic             load;
    logic             grant_found;
    logic [SEL_W-1:0] grant_idx;
    logic [WIDTH-1:0] grant_data;

    assign load = !out_valid_q || out_ready;

    // The search order is walked from last to first so the first hit in order overwrites the rest.
    always_comb begin
        int j;
        j           = 0;
        grant_found = 1'b0;
        grant_idx   = '0;
        if (prio_mode) begin
            for (int i = N - 1; i >= 0; i--) begin
                if (in_valid[i]) begin
                    grant_found = 1'b1;
                    grant_idx   = SEL_W'(i);
                end
            end
        end else begin
            for (int k = N; k >= 1; k--) begin
                j = (int'(rr_ptr_q) + k) % N;
                if (in_valid[j]) begin
                    grant_found = 1'b1;
                    grant_idx   = SEL_W'(j);
                end
            end
        end
    end

    always_comb begin
        grant_data = '0;
        for (int i = 0; i < N; i++) begin
            if (SEL_W'(i) == grant_idx) begin
                grant_data = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        in_ready = '0;
        if (!reset && load && grant_found) begin
            in_ready[grant_idx] = 1'b1;
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_sel_d   = out_sel_q;
        rr_ptr_d    = rr_ptr_q;
        if (load) begin
            if (grant_found) begin
                out_valid_d = 1'b1;
                out_data_d  = grant_data;
                out_sel_d   = grant_idx;
                rr_ptr_d    = grant_idx;
            end else begin
                out_valid_d = 1'b0;
            end
        end
    end

    // rr_ptr resets to N-1 so channel 0 wins the first round-robin arbitration.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sel_q   <= '0;
            rr_ptr_q    <= SEL_W'(N - 1);
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sel_q   <= out_sel_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sel   = out_sel_q;

endmodule

// File: tb/tb_rr_arb_mux.sv
// Directed bench for rr_arb_mux (N=8, WIDTH=32): reset, round-robin order and wrap,
// fixed priority, backpressure and reset during a stall.
module tb_rr_arb_mux;

    localparam int WIDTH = 32;
    localparam int N     = 8;

    logic             clk = 1'b0;
    logic             reset;
    logic             prio_mode;
    logic [N-1:0]     in_valid;
    logic [N*WIDTH-1:0] in_data;
    logic [N-1:0]     in_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic [2:0]       out_sel;
    logic             out_ready;

    int n_cmp = 0;
    int n_err = 0;

    rr_arb_mux #(.WIDTH(WIDTH), .N(N)) dut (
        .clk       (clk),
        .reset     (reset),
        .prio_mode (prio_mode),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running exp finished");
        $fatal(1);
    end

    task automatic load_data();
        for (int i = 0; i < N; i++) in_data[i*WIDTH +: WIDTH] = 32'hA0 + i;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; in_valid = '0; out_ready = 1'b0; prio_mode = 1'b0;
        load_data();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b1; in_valid = 8'hFF; out_ready = 1'b1; prio_mode = 1'b0;
        load_data();
        for (int c = 0; c < 2; c++) begin
            #1;
            n_cmp++; if (in_ready !== 8'h00) begin n_err++; $display("FAIL reset_in_ready: got %h exp 00", in_ready); end
            @(negedge clk);
        end
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b exp 0", out_valid); end
        n_cmp++; if (out_data !== 32'h0) begin n_err++; $display("FAIL reset_out_data: got %h exp 0", out_data); end
        n_cmp++; if (out_sel !== 3'd0) begin n_err++; $display("FAIL reset_out_sel: got %0d exp 0", out_sel); end
        reset = 1'b0;
        #1;
        n_cmp++; if (in_ready !== 8'h01) begin n_err++; $display("FAIL reset_first_grant: got %h exp 01", in_ready); end
        @(negedge clk);
        n_cmp++; if (out_valid !== 1'b1 || out_sel !== 3'd0 || out_data !== 32'hA0) begin
            n_err++; $display("FAIL reset_first_word: got v=%b sel=%0d data=%h exp v=1 sel=0 data=a0", out_valid, out_sel, out_data);
        end
    endtask

    task automatic test_rr_cycling();
        logic [2:0]  exp_sel [0:8];
        logic [31:0] exp_dat [0:8];
        for (int k = 0; k < 9; k++) begin
            exp_sel[k] = 3'(k % 8);
            exp_dat[k] = 32'hA0 + 32'(k % 8);
        end
        do_reset();
        in_valid = 8'hFF; out_ready = 1'b1;
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            n_cmp++; if (out_valid !== 1'b1 || out_sel !== exp_sel[k] || out_data !== exp_dat[k]) begin
                n_err++; $display("FAIL rr_cycle[%0d]: got v=%b sel=%0d data=%h exp v=1 sel=%0d data=%h",
                                  k, out_valid, out_sel, out_data, exp_sel[k], exp_dat[k]);
            end
        end
        in_valid = '0;
    endtask

    task automatic test_rr_wrap();
        do_reset();
        out_ready = 1'b1; in_valid = 8'h40;
        @(negedge clk);
        n_cmp++; if (out_sel !== 3'd6 || out_data !== 32'hA6) begin
            n_err++; $display("FAIL wrap_setup: got sel=%0d data=%h exp sel=6 data=a6", out_sel, out_data);
        end
        in_valid = 8'b0000_0101;
        #1;
        n_cmp++; if (in_ready !== 8'h01) begin n_err++; $display("FAIL wrap_ready0: got %h exp 01", in_ready); end
        @(negedge clk);
        n_cmp++; if (out_sel !== 3'd0 || out_data !== 32'hA0) begin
            n_err++; $display("FAIL wrap_grant0: got sel=%0d data=%h exp sel=0 data=a0", out_sel, out_data);
        end
        #1;
        n_cmp++; if (in_ready !== 8'h04) begin n_err++; $display("FAIL wrap_ready2: got %h exp 04", in_ready); end
        @(negedge clk);
        n_cmp++; if (out_sel !== 3'd2 || out_data !== 32'hA2) begin
            n_err++; $display("FAIL wrap_grant2: got sel=%0d data=%h exp sel=2 data=a2", out_sel, out_data);
        end
        @(negedge clk);
        n_cmp++; if (out_sel !== 3'd0 || out_data !== 32'hA0) begin
            n_err++; $display("FAIL wrap_grant0b: got sel=%0d data=%h exp sel=0 data=a0", out_sel, out_data);
        end
        in_valid = '0;
    endtask

    task automatic test_fixed_prio();
        do_reset();
        prio_mode = 1'b1; out_ready = 1'b1; in_valid = 8'b1001_0100;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_cmp++; if (out_valid !== 1'b1 || out_sel !== 3'd2 || out_data !== 32'hA2) begin
                n_err++; $display("FAIL fp_ch2[%0d]: got v=%b sel=%0d data=%h exp v=1 sel=2 data=a2", k, out_valid, out_sel, out_data);
            end
        end
        in_valid = 8'b1001_0000;
        @(negedge clk);
        n_cmp++; if (out_sel !== 3'd4 || out_data !== 32'hA4) begin
            n_err++; $display("FAIL fp_ch4: got sel=%0d data=%h exp sel=4 data=a4", out_sel, out_data);
        end
        // Switching back to round-robin with the pointer at 4 must pick channel 7 next.
        prio_mode = 1'b0; in_valid = 8'b1001_0100;
        #1;
        n_cmp++; if (in_ready !== 8'h80) begin n_err++; $display("FAIL fp_to_rr: got %h exp 80", in_ready); end
        n_cmp++; if (out_sel !== 3'd4) begin n_err++; $display("FAIL fp_reg_stable: got sel=%0d exp 4", out_sel); end
        in_valid = '0;
    endtask

    task automatic stall_setup();
        do_reset();
        in_data[3*WIDTH +: WIDTH] = 32'hDEAD_BEEF;
        in_valid = 8'h08; out_ready = 1'b0;
        @(negedge clk);
        n_cmp++; if (out_valid !== 1'b1 || out_sel !== 3'd3 || out_data !== 32'hDEAD_BEEF) begin
            n_err++; $display("FAIL stall_setup: got v=%b sel=%0d data=%h exp v=1 sel=3 data=deadbeef", out_valid, out_sel, out_data);
        end
    endtask

    task automatic test_backpressure();
        stall_setup();
        in_valid = 8'h20;
        for (int k = 0; k < 5; k++) begin
            #1;
            n_cmp++; if (in_ready !== 8'h00) begin n_err++; $display("FAIL bp_in_ready[%0d]: got %h exp 00", k, in_ready); end
            @(negedge clk);
            n_cmp++; if (out_valid !== 1'b1 || out_sel !== 3'd3 || out_data !== 32'hDEAD_BEEF) begin
                n_err++; $display("FAIL bp_hold[%0d]: got v=%b sel=%0d data=%h exp v=1 sel=3 data=deadbeef", k, out_valid, out_sel, out_data);
            end
        end
        out_ready = 1'b1;
        #1;
        n_cmp++; if (in_ready !== 8'h20) begin n_err++; $display("FAIL bp_release_ready: got %h exp 20", in_ready); end
        @(negedge clk);
        n_cmp++; if (out_valid !== 1'b1 || out_sel !== 3'd5 || out_data !== 32'hA5) begin
            n_err++; $display("FAIL bp_refill: got v=%b sel=%0d data=%h exp v=1 sel=5 data=a5", out_valid, out_sel, out_data);
        end
        in_valid = '0;
        load_data();
    endtask

    task automatic test_reset_mid_stall();
        stall_setup();
        in_valid = 8'hFF;
        @(negedge clk);
        reset = 1'b1;
        #1;
        n_cmp++; if (in_ready !== 8'h00) begin n_err++; $display("FAIL rms_in_ready: got %h exp 00", in_ready); end
        @(negedge clk);
        n_cmp++; if (out_valid !== 1'b0 || out_data !== 32'h0 || out_sel !== 3'd0) begin
            n_err++; $display("FAIL rms_cleared: got v=%b sel=%0d data=%h exp v=0 sel=0 data=0", out_valid, out_sel, out_data);
        end
        reset = 1'b0; out_ready = 1'b1; load_data();
        #1;
        n_cmp++; if (in_ready !== 8'h01) begin n_err++; $display("FAIL rms_ptr7: got %h exp 01", in_ready); end
        @(negedge clk);
        n_cmp++; if (out_valid !== 1'b1 || out_sel !== 3'd0 || out_data !== 32'hA0) begin
            n_err++; $display("FAIL rms_first: got v=%b sel=%0d data=%h exp v=1 sel=0 data=a0", out_valid, out_sel, out_data);
        end
        in_valid = '0;
    endtask

    initial begin
        reset = 1'b1; prio_mode = 1'b0; in_valid = '0; in_data = '0; out_ready = 1'b0;
        test_reset();
        test_rr_cycling();
        test_rr_wrap();
        test_fixed_prio();
        test_backpressure();
        test_reset_mid_stall();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
